instr_fetch_ctrl: RTL

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl
//
// Instruction fetch stage controller. Holds the program counter, addresses a
// combinational instruction memory and presents one registered instruction at
// a time to decode through a valid/ready handshake. A taken branch from execute
// redirects the PC and flushes the held instruction, which costs one bubble.
//
// Parameters
//   WORD_WIDTH  width of PC, memory address and instruction
//   RESET_PC    word address loaded into the PC on reset
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   run          fetch enable; 0 suspends new fetches
//   branch_taken redirect request from execute
//   branch_addr  redirect target word address
//   imem_addr    address to instruction memory (equals the PC)
//   imem_instr   instruction returned by memory in the same cycle
//   if_valid     if_pc / if_instr hold a valid fetched instruction
//   if_ready     decode accepts the instruction this cycle
//   if_pc        word address of if_instr
//   if_instr     registered fetched instruction
//   fetch_count  number of instructions accepted by decode (wraps)
// -----------------------------------------------------------------------------
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module instr_fetch_ctrl #(
  parameter int unsigned                  WORD_WIDTH = `WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0]        RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  branch_taken,
  input  logic [WORD_WIDTH-1:0] branch_addr,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic [WORD_WIDTH-1:0] imem_instr,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [WORD_WIDTH-1:0] if_pc,
  output logic [WORD_WIDTH-1:0] if_instr,
  output logic [15:0]           fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [WORD_WIDTH-1:0] pc;

  // Control strobes decoded from the current state and inputs.
  logic do_fetch;    // capture imem_instr and advance the PC
  logic drop_valid;  // held instruction accepted while run=0: go empty
  logic accept;      // decode takes the held instruction this cycle
  logic count_en;

  assign imem_addr = pc;
  assign accept    = if_valid & if_ready;
  // A branch in the same cycle as acceptance flushes the instruction, so it
  // is not counted.
  assign count_en  = accept & ~branch_taken;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_next = state;
    do_fetch   = 1'b0;
    drop_valid = 1'b0;

    if (branch_taken) begin
      // Redirect wins over everything, including a pending acceptance.
      state_next = run ? FETCH : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          // One cycle here before fetching resumes; PC holds.
          if (run) state_next = FETCH;
        end

        FETCH: begin
          if (if_valid && !if_ready) begin
            state_next = STALL;
          end else if (run) begin
            do_fetch = 1'b1;
          end else begin
            // Empty, or held instruction accepted now: stop fetching.
            drop_valid = 1'b1;
            state_next = IDLE;
          end
        end

        STALL: begin
          if (if_ready) begin
            if (run) begin
              do_fetch   = 1'b1;
              state_next = FETCH;
            end else begin
              drop_valid = 1'b1;
              state_next = IDLE;
            end
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // PC and fetch output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else if (branch_taken) begin
      // Flush: the instruction fetched from the old path is discarded and the
      // target is fetched on the following edge (one bubble).
      pc       <= branch_addr;
      if_valid <= 1'b0;
    end else if (do_fetch) begin
      if_instr <= imem_instr;
      if_pc    <= pc;
      if_valid <= 1'b1;
      pc       <= pc + WORD_WIDTH'(1);  // wraps silently at the top
    end else if (drop_valid) begin
      if_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Accepted-instruction counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           fetch_count <= '0;
    else if (count_en) fetch_count <= fetch_count + 16'd1;
  end

endmodule
